// File: rtl/hi_pkg.sv
// Shared Host Interface definitions: transaction FSM state encoding and HI word length.
package hi_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD_REQ = 3'd1;
  localparam logic [2:0] ST_RD     = 3'd2;
  localparam logic [2:0] ST_WR     = 3'd3;
  localparam logic [2:0] ST_FIN    = 3'd4;
  localparam logic [2:0] ST_RSP    = 3'd5;

  localparam logic [31:0] HI_WORD_LEN = 32'd4;

endpackage

// File: rtl/hi_rsp_reg.sv
// One-entry response holding register: collects read data, status and abort flag,
// and presents them with a valid/ready handshake until consumed.
module hi_rsp_reg (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_ld_data,
  input  logic [31:0] i_data,
  input  logic        i_ld_status,
  input  logic [15:0] i_status,
  input  logic        i_abort,
  input  logic        i_set_valid,
  input  logic        i_rsp_ready,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_data,
  output logic [15:0] o_rsp_status,
  output logic        o_rsp_timeout,
  output logic        o_hs
);

  logic        r_valid;
  logic [31:0] r_data;
  logic [15:0] r_status;
  logic        r_timeout;

  assign o_hs          = r_valid && i_rsp_ready;
  assign o_rsp_valid   = r_valid;
  assign o_rsp_data    = r_data;
  assign o_rsp_status  = r_status;
  assign o_rsp_timeout = r_timeout;

  // Payload: cleared on a new command, zeroed with the abort flag on timeout
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data    <= 32'h0;
      r_status  <= 16'h0;
      r_timeout <= 1'b0;
    end else if (i_clr) begin
      r_data    <= 32'h0;
      r_status  <= 16'h0;
      r_timeout <= 1'b0;
    end else if (i_abort) begin
      r_data    <= 32'h0;
      r_status  <= 16'h0;
      r_timeout <= 1'b1;
    end else begin
      if (i_ld_data) begin
        r_data <= i_data;
      end
      if (i_ld_status) begin
        r_status <= i_status;
      end
    end
  end

  // Valid flag: set on entry to the response phase, dropped on handshake
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
    end else if (i_set_valid) begin
      r_valid <= 1'b1;
    end else if (o_hs) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/hi_cmd_master.sv
// Single-word HI master: converts one valid/ready command into a complete HI read or
// write, with timeout abort and arbiter locking across chained commands.
module hi_cmd_master #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 16
) (
  input  logic        ifclk,
  input  logic        resetb,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_lock,
  input  logic [15:0] cmd_term,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [15:0] rsp_status,
  output logic        rsp_timeout,
  output logic [15:0] di_term_addr,
  output logic [31:0] di_reg_addr,
  output logic [31:0] di_len,
  output logic        di_write_mode,
  output logic        di_write,
  output logic [31:0] di_reg_datai,
  input  logic        di_write_rdy,
  output logic        di_read_mode,
  output logic        di_read_req,
  output logic        di_read,
  input  logic        di_read_rdy,
  input  logic [31:0] di_reg_datao,
  input  logic [15:0] di_transfer_status,
  output logic        lock_arbiter
);
  import hi_pkg::*;

  localparam logic [TO_W-1:0] TO_LIM  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_LIM - {{(TO_W-1){1'b0}}, 1'b1};

  logic [2:0]      r_state;
  logic [2:0]      w_state_nxt;
  logic [TO_W-1:0] r_cnt;
  logic            r_write;
  logic            r_lock;
  logic            r_lock_arb;
  logic [15:0]     r_term;
  logic [31:0]     r_addr;
  logic [31:0]     r_data;
  logic            w_accept;
  logic            w_hs;
  logic            w_to_hit;
  logic            w_abort;
  logic            w_set_valid;

  assign w_accept     = cmd_valid && (r_state == ST_IDLE);
  // Fires on the cycle whose increment brings the count to the limit
  assign w_to_hit     = (TO_LIM != {TO_W{1'b0}}) && (r_cnt >= TO_LAST);
  assign w_abort      = w_to_hit && (((r_state == ST_RD) && !di_read_rdy) ||
                                     ((r_state == ST_WR) && !di_write_rdy));
  assign w_set_valid  = (w_state_nxt == ST_RSP) && (r_state != ST_RSP);

  assign di_term_addr = r_term;
  assign di_reg_addr  = r_addr;
  assign di_reg_datai = r_data;
  assign di_len       = HI_WORD_LEN;
  assign lock_arbiter = r_lock_arb;

  // State register
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a ready in the timeout cycle wins over the abort
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   w_state_nxt = cmd_valid ? (cmd_write ? ST_WR : ST_RD_REQ) : ST_IDLE;
      ST_RD_REQ: w_state_nxt = ST_RD;
      ST_RD:     w_state_nxt = di_read_rdy  ? ST_FIN : (w_to_hit ? ST_RSP : ST_RD);
      ST_WR:     w_state_nxt = di_write_rdy ? ST_FIN : (w_to_hit ? ST_RSP : ST_WR);
      ST_FIN:    w_state_nxt = ST_RSP;
      ST_RSP:    w_state_nxt = w_hs ? ST_IDLE : ST_RSP;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // HI control outputs decoded from state
  always_comb begin
    cmd_ready     = 1'b0;
    di_read_mode  = 1'b0;
    di_read_req   = 1'b0;
    di_read       = 1'b0;
    di_write_mode = 1'b0;
    di_write      = 1'b0;
    case (r_state)
      ST_IDLE:   cmd_ready = 1'b1;
      ST_RD_REQ: begin
        di_read_mode = 1'b1;
        di_read_req  = 1'b1;
      end
      ST_RD: begin
        di_read_mode = 1'b1;
        di_read      = di_read_rdy;
      end
      ST_WR: begin
        di_write_mode = 1'b1;
        di_write      = 1'b1;
      end
      ST_FIN: begin
        di_read_mode  = !r_write;
        di_write_mode = r_write;
      end
      default: cmd_ready = 1'b0;
    endcase
  end

  // Command latch
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      r_write <= 1'b0;
      r_lock  <= 1'b0;
      r_term  <= 16'h0;
      r_addr  <= 32'h0;
      r_data  <= 32'h0;
    end else if (w_accept) begin
      r_write <= cmd_write;
      r_lock  <= cmd_lock;
      r_term  <= cmd_term;
      r_addr  <= cmd_addr;
      r_data  <= cmd_data;
    end
  end

  // Saturating wait counter for RD/WR
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      r_cnt <= {TO_W{1'b0}};
    end else if (w_accept) begin
      r_cnt <= {TO_W{1'b0}};
    end else if (((r_state == ST_RD) || (r_state == ST_WR)) && (r_cnt != {TO_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(TO_W-1){1'b0}}, 1'b1};
    end
  end

  // Arbiter lock: held from accept, then follows the command's lock bit after the response
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      r_lock_arb <= 1'b0;
    end else if (w_accept) begin
      r_lock_arb <= 1'b1;
    end else if (w_hs) begin
      r_lock_arb <= r_lock;
    end
  end

  hi_rsp_reg u_rsp (
    .i_clk         (ifclk),
    .i_rst_n       (resetb),
    .i_clr         (w_accept),
    .i_ld_data     ((r_state == ST_RD) && di_read_rdy),
    .i_data        (di_reg_datao),
    .i_ld_status   (r_state == ST_FIN),
    .i_status      (di_transfer_status),
    .i_abort       (w_abort),
    .i_set_valid   (w_set_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_valid   (rsp_valid),
    .o_rsp_data    (rsp_data),
    .o_rsp_status  (rsp_status),
    .o_rsp_timeout (rsp_timeout),
    .o_hs          (w_hs)
  );

endmodule

// File: tb/tb_hi_cmd_master.sv
// Directed bench for hi_cmd_master: write, read, back-pressure, lock chain, timeout, reset.
module tb_hi_cmd_master;

  logic        ifclk = 1'b0;
  logic        resetb;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_lock;
  logic [15:0] cmd_term;
  logic [31:0] cmd_addr, cmd_data;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_data;
  logic [15:0] rsp_status;
  logic [15:0] di_term_addr;
  logic [31:0] di_reg_addr, di_len, di_reg_datai, di_reg_datao;
  logic        di_write_mode, di_write, di_write_rdy;
  logic        di_read_mode, di_read_req, di_read, di_read_rdy;
  logic [15:0] di_transfer_status;
  logic        lock_arbiter;

  int n_cmp = 0;
  int n_err = 0;
  int wr_xfers = 0;
  int rd_reqs = 0;
  int lock_lows = 0;
  int snap_wr, snap_rq, snap_lk;

  always #5 ifclk = ~ifclk;

  hi_cmd_master #(.TIMEOUT_CYCLES(8), .TO_W(16)) dut (
    .ifclk(ifclk), .resetb(resetb),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_lock(cmd_lock),
    .cmd_term(cmd_term), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_status(rsp_status), .rsp_timeout(rsp_timeout),
    .di_term_addr(di_term_addr), .di_reg_addr(di_reg_addr), .di_len(di_len),
    .di_write_mode(di_write_mode), .di_write(di_write), .di_reg_datai(di_reg_datai),
    .di_write_rdy(di_write_rdy),
    .di_read_mode(di_read_mode), .di_read_req(di_read_req), .di_read(di_read),
    .di_read_rdy(di_read_rdy), .di_reg_datao(di_reg_datao),
    .di_transfer_status(di_transfer_status), .lock_arbiter(lock_arbiter)
  );

  // Event counters sampled mid-cycle
  always @(negedge ifclk) begin
    if (di_write && di_write_rdy) wr_xfers <= wr_xfers + 1;
    if (di_read_req) rd_reqs <= rd_reqs + 1;
    if (!lock_arbiter) lock_lows <= lock_lows + 1;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ifclk);
    #1;
  endtask

  task automatic mid();
    @(negedge ifclk);
  endtask

  initial begin
    resetb = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_lock = 1'b0;
    cmd_term = 16'h0; cmd_addr = 32'h0; cmd_data = 32'h0; rsp_ready = 1'b0;
    di_write_rdy = 1'b0; di_read_rdy = 1'b0; di_reg_datao = 32'h0; di_transfer_status = 16'h0;

    // Reset state
    mid();
    chk1("rst_cmd_ready", cmd_ready, 1'b1);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_wmode", di_write_mode, 1'b0);
    chk1("rst_rmode", di_read_mode, 1'b0);
    chk1("rst_lock", lock_arbiter, 1'b0);
    chk32("rst_len", di_len, 32'd4);
    chk32("rst_rsp_data", rsp_data, 32'h0);
    cyc(); cyc(); resetb = 1'b1;

    // Write, di_write_rdy two cycles after WR entry
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_lock = 1'b0; cmd_term = 16'h0003;
    cmd_addr = 32'h10; cmd_data = 32'hDEADBEEF; di_transfer_status = 16'h1111;
    mid(); chk1("w_idle_ready", cmd_ready, 1'b1);
    cyc(); cmd_valid = 1'b0; cmd_data = 32'h0;
    mid(); snap_wr = wr_xfers;
    chk1("w_mode", di_write_mode, 1'b1);
    chk1("w_write", di_write, 1'b1);
    chk32("w_datai", di_reg_datai, 32'hDEADBEEF);
    chk16("w_term", di_term_addr, 16'h0003);
    chk32("w_addr", di_reg_addr, 32'h10);
    chk1("w_lock", lock_arbiter, 1'b1);
    cyc(); mid(); chk1("w_write2", di_write, 1'b1);
    cyc(); di_write_rdy = 1'b1;
    mid(); chk1("w_write3", di_write, 1'b1);
    cyc(); di_write_rdy = 1'b0; di_transfer_status = 16'hA5A5;
    mid(); chk1("w_fin_mode", di_write_mode, 1'b1);
    chk1("w_fin_write", di_write, 1'b0);
    chk1("w_fin_valid", rsp_valid, 1'b0);
    cyc(); di_transfer_status = 16'h2222; rsp_ready = 1'b1;
    mid(); chk1("w_rsp_valid", rsp_valid, 1'b1);
    chk16("w_rsp_status", rsp_status, 16'hA5A5);
    chk1("w_rsp_timeout", rsp_timeout, 1'b0);
    chk32("w_rsp_data", rsp_data, 32'h0);
    chk1("w_rsp_mode", di_write_mode, 1'b0);
    chk1("w_rsp_cmd_ready", cmd_ready, 1'b0);
    chk32("w_xfer_count", 32'(wr_xfers - snap_wr), 32'd1);
    cyc(); rsp_ready = 1'b0;
    mid(); chk1("w_done_valid", rsp_valid, 1'b0);
    chk1("w_done_ready", cmd_ready, 1'b1);
    chk1("w_done_lock", lock_arbiter, 1'b0);

    // Read with lock=1, data after five RD cycles
    snap_rq = rd_reqs;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_lock = 1'b1; cmd_term = 16'h0005; cmd_addr = 32'h20;
    cyc(); cmd_valid = 1'b0;
    mid(); snap_lk = lock_lows;
    chk1("r_req", di_read_req, 1'b1);
    chk1("r_req_mode", di_read_mode, 1'b1);
    chk1("r_req_lock", lock_arbiter, 1'b1);
    chk32("r_addr", di_reg_addr, 32'h20);
    chk1("r_req_cmd_ready", cmd_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(); mid();
      chk1("r_wait_req", di_read_req, 1'b0);
      chk1("r_wait_mode", di_read_mode, 1'b1);
      chk1("r_wait_read", di_read, 1'b0);
    end
    cyc(); di_read_rdy = 1'b1; di_reg_datao = 32'h12345678;
    mid(); chk1("r_read", di_read, 1'b1);
    cyc(); di_read_rdy = 1'b0; di_reg_datao = 32'hFFFFFFFF; di_transfer_status = 16'h0BAD;
    mid(); chk1("r_fin_mode", di_read_mode, 1'b1);
    chk1("r_fin_read", di_read, 1'b0);
    cyc(); di_transfer_status = 16'h3333;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_lock = 1'b0; cmd_term = 16'h0007;
    cmd_addr = 32'h44; cmd_data = 32'h0BADF00D;
    mid(); chk1("r_rsp_valid", rsp_valid, 1'b1);
    chk32("r_rsp_data", rsp_data, 32'h12345678);
    chk16("r_rsp_status", rsp_status, 16'h0BAD);
    chk1("r_rsp_timeout", rsp_timeout, 1'b0);
    chk32("r_req_count", 32'(rd_reqs - snap_rq), 32'd1);

    // Back-pressure with a pending command
    for (int i = 0; i < 10; i++) begin
      cyc(); mid();
      chk1("bp_valid", rsp_valid, 1'b1);
      chk32("bp_data", rsp_data, 32'h12345678);
      chk16("bp_status", rsp_status, 16'h0BAD);
      chk1("bp_cmd_ready", cmd_ready, 1'b0);
      chk1("bp_rmode", di_read_mode, 1'b0);
      chk1("bp_wmode", di_write_mode, 1'b0);
      chk1("bp_lock", lock_arbiter, 1'b1);
    end
    rsp_ready = 1'b1;
    cyc(); rsp_ready = 1'b0;
    mid(); chk1("lc_idle_valid", rsp_valid, 1'b0);
    chk1("lc_idle_ready", cmd_ready, 1'b1);
    chk1("lc_idle_lock", lock_arbiter, 1'b1);
    di_write_rdy = 1'b1;

    // Chained write with lock=0, ready already high
    cyc(); cmd_valid = 1'b0;
    mid(); snap_wr = wr_xfers;
    chk1("lc_write", di_write, 1'b1);
    chk32("lc_datai", di_reg_datai, 32'h0BADF00D);
    chk32("lc_addr", di_reg_addr, 32'h44);
    chk16("lc_term", di_term_addr, 16'h0007);
    cyc(); di_write_rdy = 1'b0; di_transfer_status = 16'h7E57;
    mid(); chk1("lc_fin_mode", di_write_mode, 1'b1);
    chk1("lc_fin_valid", rsp_valid, 1'b0);
    cyc(); rsp_ready = 1'b1;
    mid(); chk1("lc_rsp_valid", rsp_valid, 1'b1);
    chk16("lc_rsp_status", rsp_status, 16'h7E57);
    chk32("lc_rsp_data", rsp_data, 32'h0);
    chk1("lc_rsp_lock", lock_arbiter, 1'b1);
    chk32("lc_lock_gaps", 32'(lock_lows - snap_lk), 32'd0);
    chk32("lc_xfer_count", 32'(wr_xfers - snap_wr), 32'd1);
    cyc(); rsp_ready = 1'b0;
    mid(); chk1("lc_done_lock", lock_arbiter, 1'b0);
    chk1("lc_done_ready", cmd_ready, 1'b1);
    chk1("lc_done_valid", rsp_valid, 1'b0);

    // Read timeout: 8 cycles in RD
    di_reg_datao = 32'h55555555; di_transfer_status = 16'h9999;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_lock = 1'b0; cmd_addr = 32'h30;
    cyc(); cmd_valid = 1'b0;
    mid(); chk1("to_req", di_read_req, 1'b1);
    cyc(); mid();
    chk1("to_rd1_mode", di_read_mode, 1'b1);
    chk1("to_rd1_valid", rsp_valid, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(); mid();
      chk1("to_wait_valid", rsp_valid, 1'b0);
    end
    cyc(); mid();
    chk1("to_rd8_mode", di_read_mode, 1'b1);
    chk1("to_rd8_valid", rsp_valid, 1'b0);
    cyc(); mid();
    chk1("to_rsp_valid", rsp_valid, 1'b1);
    chk1("to_rsp_timeout", rsp_timeout, 1'b1);
    chk32("to_rsp_data", rsp_data, 32'h0);
    chk16("to_rsp_status", rsp_status, 16'h0);
    chk1("to_rsp_rmode", di_read_mode, 1'b0);
    chk1("to_rsp_req", di_read_req, 1'b0);
    rsp_ready = 1'b1;
    cyc(); rsp_ready = 1'b0;
    mid(); chk1("to_done_valid", rsp_valid, 1'b0);
    chk1("to_done_ready", cmd_ready, 1'b1);

    // Async reset in the middle of a write
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_data = 32'hCAFEF00D; di_write_rdy = 1'b0;
    cyc(); cmd_valid = 1'b0;
    mid(); chk1("rs_wmode_before", di_write_mode, 1'b1);
    #1 resetb = 1'b0;
    #1;
    chk1("rs_wmode_async", di_write_mode, 1'b0);
    chk1("rs_write_async", di_write, 1'b0);
    chk1("rs_lock_async", lock_arbiter, 1'b0);
    chk1("rs_ready_async", cmd_ready, 1'b1);
    cyc(); cyc(); resetb = 1'b1; rsp_ready = 1'b1;
    mid(); chk1("rs_cmd_ready", cmd_ready, 1'b1);
    chk1("rs_rsp_valid", rsp_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(); mid();
      chk1("rs_no_rsp", rsp_valid, 1'b0);
      chk1("rs_no_wmode", di_write_mode, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hi_cmd_master.md
# hi_cmd_master

Single-word Host Interface master that turns a simple valid/ready command stream into one complete HI read or write transaction. It sits directly upstream of the HI arbiter and drives one host slot of that arbiter. It lets on-chip logic such as sequencers, CPUs or init ROMs access the same terminals as the external host. It handles HI mode/request/ready sequencing, timeouts and arbiter locking for read-modify-write sequences.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024, wait cycles allowed for di_write_rdy/di_read_rdy before abort; 0 disables timeout
- TO_W, 16, timeout counter width; must satisfy TIMEOUT_CYCLES < 2^TO_W

Ports (one clock; reset is asynchronous and active-low):
- ifclk  in  1  clock
- resetb  in  1  async active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_write  in  1  1=write, 0=read
- cmd_lock  in  1  keep arbiter locked after this command completes
- cmd_term  in  16  terminal address
- cmd_addr  in  32  register address
- cmd_data  in  32  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&&ready
- rsp_data  out  32  read data (0 for writes or timeout)
- rsp_status  out  16  captured di_transfer_status
- rsp_timeout  out  1  transaction aborted by timeout
- di_term_addr  out  16 ; di_reg_addr  out  32 ; di_len  out  32  transaction target; di_len is fixed at 4 (bytes)
- di_write_mode  out  1 ; di_write  out  1 ; di_reg_datai  out  32 ; di_write_rdy  in  1
- di_read_mode  out  1 ; di_read_req  out  1 ; di_read  out  1 ; di_read_rdy  in  1 ; di_reg_datao  in  32
- di_transfer_status  in  16
- lock_arbiter  out  1  connects to the arbiter lock input for this slot

## Operation
- States: IDLE, RD_REQ, RD, WR, FIN, RSP. Reset state is IDLE.
- IDLE:
  - cmd_ready=1.
  - On accept, register write/lock/term/addr/data, clear the timeout counter, and go to WR (write) or RD_REQ (read).
- RD_REQ: one cycle with di_read_mode=1 and di_read_req=1, then go to RD.
- RD:
  - di_read_mode=1 and di_read=di_read_rdy (combinational).
  - On the di_read_rdy cycle, capture di_reg_datao into rsp_data and go to FIN.
- WR:
  - di_write_mode=1, di_write=1, di_reg_datai=latched data.
  - The transfer occurs on the cycle where di_write_rdy=1; then go to FIN.
- FIN:
  - The active mode stays asserted for this cycle.
  - Capture di_transfer_status into rsp_status, then go to RSP.
- RSP:
  - Both modes are deasserted and rsp_valid=1.
  - On rsp_ready, go to IDLE.
- Timeout:
  - The counter increments each cycle spent in RD or WR.
  - When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES≠0), go directly to RSP with rsp_timeout=1, rsp_data=0, rsp_status=0.
  - The counter saturates and never wraps.
- Lock:
  - lock_arbiter rises in the cycle after accept and stays high through the response.
  - On the RSP handshake, lock_arbiter takes the latched cmd_lock value.
  - A chain of lock=1 commands therefore keeps the arbiter held until a lock=0 command completes.
- di_term_addr, di_reg_addr and di_reg_datai hold their latched values in every state (including IDLE) and are stable throughout each transaction.

## Timing
- Reset values: cmd_ready=1 (IDLE); every other output is 0, including rsp_*, di_*_mode, di_read_req, di_write, di_read and lock_arbiter. di_len is the constant 4.
- Reset asserted mid-transaction drops the modes immediately (async) and discards the command; no response is produced.
- Minimum latency from accept to rsp_valid, with ready already high:
  - write: 3 cycles (WR, FIN, RSP).
  - read: 4 cycles (RD_REQ, RD, FIN, RSP).
- A new command cannot be accepted in the same cycle as the RSP handshake; cmd_ready rises the following cycle.
- di_read_req is a single-cycle pulse per read; it is never reasserted during the transaction.
- A timeout and a ready arriving in the same cycle resolve to the ready (normal completion).

## Structure
- A shared hi_pkg holds the state encoding localparams and the HI_WORD_LEN=4 constant.
- The response register plus its valid/ready logic forms a natural sub-module, hi_rsp_reg (a one-entry skid holding register).

## Test plan
- Write: cmd term=0x0003, addr=0x10, data=0xDEADBEEF; di_write_rdy high 2 cycles after WR entry -> exactly one di_write&&di_write_rdy cycle carrying 0xDEADBEEF; rsp_status equals di_transfer_status in FIN; rsp_timeout=0.
- Read: cmd read addr=0x20; device returns 0x12345678 after 5 cycles -> di_read_req pulses exactly once; rsp_data=0x12345678.
- Timeout: TIMEOUT_CYCLES=8, di_read_rdy never asserts -> rsp_valid 8 cycles after RD entry with rsp_timeout=1, rsp_data=0; modes drop.
- Back-pressure: hold rsp_ready=0 for 10 cycles -> rsp_* stable, cmd_ready=0 throughout, modes low.
- Lock chain: read(lock=1), then write(lock=0) -> lock_arbiter high continuously from the first accept until the second RSP handshake, then low.
- Reset: drop resetb during WR -> di_write_mode=0 asynchronously; after release, cmd_ready=1 and no response is produced.
